// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command executor behind the SPI scan chain.
// Takes the 16-bit word latched on the rising edge of nCS (i_load). The word
// is split into a 4-bit opcode and a 12-bit argument. It drives a PWM
// generator, an 8-bit output register and an optional one-shot timer.
// Writes only take effect after the unlock word 16'hCAFE.
// Optional feature: define SPI_CMD_ONESHOT_EN to build the one-shot timer and
// opcode 0x5. Without it, o_pulse and o_busy are tied low and 0x5 is an
// undefined opcode.
module spi_cmd_ctrl #(
  parameter int CNT_W = 12
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_load,
  input  logic [15:0] i_data,
  output logic        o_pwm,
  output logic [7:0]  o_gpo,
  output logic        o_pulse,
  output logic        o_busy,
  output logic        o_unlocked,
  output logic        o_err
);

  localparam logic [15:0] UNLOCK_WORD = 16'hCAFE;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_DUTY    = 4'h1;
  localparam logic [3:0] OP_PERIOD  = 4'h2;
  localparam logic [3:0] OP_PWM_EN  = 4'h3;
  localparam logic [3:0] OP_GPO     = 4'h4;
  localparam logic [3:0] OP_ONESHOT = 4'h5;
  localparam logic [3:0] OP_LOCK    = 4'hF;

  // i_load synchroniser and edge detect
  logic load_s1;
  logic load_s2;
  logic load_s3;
  logic load_rise;

  // Captured command.
  // Handshake: cmd_v is a one-cycle strobe that qualifies cmd_r. There is no
  // ready or backpressure. The executor always consumes the word on the
  // cycle after the strobe. The source must space words so that i_load stays
  // low for at least 3 clocks between rising edges.
  logic [15:0]      cmd_r;
  logic             cmd_v;
  logic [3:0]       opcode;
  logic [CNT_W-1:0] arg;
  logic             exec_ok;

  // Control registers
  logic       unlocked;
  logic       err;
  logic [7:0] gpo;

  // PWM state
  logic             pwm_en;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic             pwm_q;

  // One-shot status
  logic busy;

  // Two-flop synchroniser on nCS, plus a third flop for rising-edge detect
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      load_s1 <= 1'b0;
      load_s2 <= 1'b0;
      load_s3 <= 1'b0;
    end else begin
      load_s1 <= i_load;
      load_s2 <= load_s1;
      load_s3 <= load_s2;
    end
  end

  assign load_rise = load_s2 & ~load_s3;

  // Latch the scan-chain word on a synced rising edge and strobe cmd_v
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      cmd_r <= '0;
      cmd_v <= 1'b0;
    end else begin
      cmd_v <= load_rise;
      if (load_rise) begin
        cmd_r <= i_data;
      end
    end
  end

  assign opcode  = cmd_r[15:12];
  assign arg     = CNT_W'(cmd_r[11:0]);
  // An ordinary (non-cookie) word that is allowed to execute this cycle
  assign exec_ok = cmd_v && unlocked && (cmd_r != UNLOCK_WORD);

  // Command decode: lock state, sticky error, GPO and PWM shadow registers
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      unlocked  <= 1'b0;
      err       <= 1'b0;
      gpo       <= '0;
      pwm_en    <= 1'b0;
      duty_sh   <= '0;
      period_sh <= '0;
    end else if (cmd_v) begin
      if (cmd_r == UNLOCK_WORD) begin
        unlocked <= 1'b1;
        err      <= 1'b0;
      end else if (!unlocked) begin
        err <= 1'b1;
      end else begin
        case (opcode)
          OP_NOP:    ;
          OP_DUTY:   duty_sh   <= arg;
          OP_PERIOD: period_sh <= arg;
          OP_PWM_EN: pwm_en    <= cmd_r[0];
          OP_GPO:    gpo       <= cmd_r[7:0];
`ifdef SPI_CMD_ONESHOT_EN
          // A zero argument is a no-op. A retrigger while running is refused.
          OP_ONESHOT: begin
            if (busy && (arg != '0)) begin
              err <= 1'b1;
            end
          end
`endif
          OP_LOCK:   unlocked <= 1'b0;
          default:   err      <= 1'b1;
        endcase
      end
    end
  end

  // PWM: counter runs 0..period. Shadows load at wrap, or freely while disabled.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      cnt    <= '0;
      duty   <= '0;
      period <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pwm_q <= pwm_en && (cnt < duty);
      if (!pwm_en) begin
        cnt    <= '0;
        duty   <= duty_sh;
        period <= period_sh;
      end else if (cnt >= period) begin
        cnt    <= '0;
        duty   <= duty_sh;
        period <= period_sh;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SPI_CMD_ONESHOT_EN
  logic [CNT_W-1:0] os_cnt;
  logic             os_start;

  assign os_start = exec_ok && (opcode == OP_ONESHOT) && (arg != '0) && !busy;
  assign busy     = (os_cnt != '0);

  // One-shot down-counter: loaded with arg on start, the pulse lasts while it is non-zero
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      os_cnt <= '0;
    end else if (os_start) begin
      os_cnt <= arg;
    end else if (busy) begin
      os_cnt <= os_cnt - CNT_W'(1);
    end
  end
`else
  assign busy = 1'b0;
`endif

  assign o_pwm      = pwm_q;
  assign o_gpo      = gpo;
  assign o_pulse    = busy;
  assign o_busy     = busy;
  assign o_unlocked = unlocked;
  assign o_err      = err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: self-checking bench for spi_cmd_ctrl.
// It keeps a behavioural model: each word takes effect on the fourth clock
// edge after i_load rises. The model tracks PWM position, one-shot remaining
// cycles and the lock/error state using plain integers. A compare process
// checks every output on each falling edge. Directed literal checks pin the
// model. Honours SPI_CMD_ONESHOT_EN the same way the design does.
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_resetn = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic        o_pwm;
  logic [7:0]  o_gpo;
  logic        o_pulse;
  logic        o_busy;
  logic        o_unlocked;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  spi_cmd_ctrl #(.CNT_W(12)) dut (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_load     (i_load),
    .i_data     (i_data),
    .o_pwm      (o_pwm),
    .o_gpo      (o_gpo),
    .o_pulse    (o_pulse),
    .o_busy     (o_busy),
    .o_unlocked (o_unlocked),
    .o_err      (o_err)
  );

  // ---------------- counters / check helper ----------------
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          at;
    logic [15:0] w;
  } pend_t;

  pend_t exp_q[$];   // words waiting for their execute edge
  int    cyc = 0;    // rising edges seen so far

  bit          m_unl = 0;
  bit          m_err = 0;
  logic [7:0]  m_gpo = 8'h00;
  bit          m_en = 0;
  int          m_duty = 0;
  int          m_per = 0;
  int          m_duty_sh = 0;
  int          m_per_sh = 0;
  int          m_pos = 0;
  bit          m_pwm = 0;
  int          m_os = 0;      // one-shot cycles still to run

  function automatic void model_exec(input logic [15:0] w, input bit busy_before);
    int arg;
    arg = int'(w[11:0]);
    if (w == 16'hCAFE) begin
      m_unl = 1;
      m_err = 0;
    end else if (!m_unl) begin
      m_err = 1;
    end else begin
      case (w[15:12])
        4'h0: ;
        4'h1: m_duty_sh = arg;
        4'h2: m_per_sh  = arg;
        4'h3: m_en      = w[0];
        4'h4: m_gpo     = w[7:0];
        4'h5: begin
`ifdef SPI_CMD_ONESHOT_EN
          if (arg != 0) begin
            if (busy_before) m_err = 1;
            else m_os = arg;
          end
`else
          m_err = 1;
`endif
        end
        4'hF: m_unl = 0;
        default: m_err = 1;
      endcase
    end
  endfunction

  // Model advance: one step per clock, reset clears everything at once
  always @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      m_unl = 0; m_err = 0; m_gpo = 8'h00; m_en = 0;
      m_duty = 0; m_per = 0; m_duty_sh = 0; m_per_sh = 0;
      m_pos = 0; m_pwm = 0; m_os = 0;
      exp_q.delete();
    end else begin
      bit busy_before;
      cyc++;
      busy_before = (m_os > 0);
      // output of the coming cycle reflects the position held before this edge
      m_pwm = m_en && (m_pos < m_duty);
      if (!m_en || m_pos >= m_per) begin
        m_pos  = 0;
        m_duty = m_duty_sh;
        m_per  = m_per_sh;
      end else begin
        m_pos++;
      end
      if (m_os > 0) m_os--;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        pend_t p;
        p = exp_q.pop_front();
        model_exec(p.w, busy_before);
      end
    end
  end

  // Compare process: every output on every falling edge out of reset
  always @(negedge i_clk) begin
    if (i_resetn) begin
      chk("gpo",      16'(o_gpo),      16'(m_gpo));
      chk("unlocked", 16'(o_unlocked), 16'(m_unl));
      chk("err",      16'(o_err),      16'(m_err));
      chk("pwm",      16'(o_pwm),      16'(m_pwm));
      chk("pulse",    16'(o_pulse),    16'(m_os > 0));
      chk("busy",     16'(o_busy),     16'(m_os > 0));
    end
  end

  // Running total of cycles with o_pulse high
  int pulse_total = 0;
  always @(negedge i_clk) begin
    if (o_pulse) pulse_total++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [15:0] w, input int hi, input int lo);
    @(negedge i_clk);
    i_data = w;
    i_load = 1'b1;
    exp_q.push_back('{cyc + 4, w});
    repeat (hi) @(negedge i_clk);
    i_load = 1'b0;
    repeat (lo - 1) @(negedge i_clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge i_clk);
      if (o_pwm) hi++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi_cnt;
    int p0;
    logic [3:0]  op;
    logic [11:0] arg;
    logic [15:0] w;

    // reset state
    i_resetn = 1'b0;
    wait_cycles(3);
    chk("rst_gpo",      16'(o_gpo),      16'h0000);
    chk("rst_unlocked", 16'(o_unlocked), 16'h0000);
    chk("rst_pwm",      16'(o_pwm),      16'h0000);
    chk("rst_busy",     16'(o_busy),     16'h0000);
    i_resetn = 1'b1;
    wait_cycles(2);

    // write while locked is refused and flagged
    send_word(16'h4055, 3, 3);
    wait_cycles(2);
    chk("locked_gpo", 16'(o_gpo), 16'h0000);
    chk("locked_err", 16'(o_err), 16'h0001);

    // unlock clears the error
    send_word(16'hCAFE, 3, 3);
    wait_cycles(2);
    chk("unlock_unl", 16'(o_unlocked), 16'h0001);
    chk("unlock_err", 16'(o_err),      16'h0000);

    // exact latency: gpo changes on the 4th edge after i_load rises
    @(negedge i_clk);
    i_data = 16'h4055;
    i_load = 1'b1;
    exp_q.push_back('{cyc + 4, 16'h4055});
    repeat (3) @(posedge i_clk);
    #1 chk("gpo_edge3", 16'(o_gpo), 16'h0000);
    @(posedge i_clk);
    #1 chk("gpo_edge4", 16'(o_gpo), 16'h0055);
    @(negedge i_clk);
    i_load = 1'b0;
    wait_cycles(4);

    // PWM: period 9 (10 cycles), duty 3
    send_word(16'h2009, 3, 3);
    send_word(16'h1003, 3, 3);
    send_word(16'h3001, 3, 3);
    wait_cycles(15);
    count_pwm(30, hi_cnt);
    chk("pwm_3of10", 16'(hi_cnt), 16'd9);
    send_word(16'h1000, 3, 3);
    wait_cycles(12);
    count_pwm(20, hi_cnt);
    chk("pwm_duty0", 16'(hi_cnt), 16'd0);

    // duty above period gives constant high; disabling forces low
    send_word(16'h100A, 3, 3);
    send_word(16'h2004, 3, 3);
    wait_cycles(12);
    count_pwm(20, hi_cnt);
    chk("pwm_const1", 16'(hi_cnt), 16'd20);
    send_word(16'h3000, 3, 3);
    wait_cycles(2);
    count_pwm(20, hi_cnt);
    chk("pwm_off", 16'(hi_cnt), 16'd0);

    // one-shot, retrigger mid-pulse, zero-length request
    p0 = pulse_total;
    send_word(16'h5005, 1, 3);
    send_word(16'h5003, 1, 3);
    wait_cycles(20);
`ifdef SPI_CMD_ONESHOT_EN
    chk("oneshot_len", 16'(pulse_total - p0), 16'd5);
`else
    chk("oneshot_len", 16'(pulse_total - p0), 16'd0);
`endif
    chk("oneshot_retrig_err", 16'(o_err), 16'h0001);
    send_word(16'hCAFE, 3, 3);
    p0 = pulse_total;
    send_word(16'h5000, 3, 3);
    wait_cycles(10);
    chk("oneshot_zero_len", 16'(pulse_total - p0), 16'd0);
`ifdef SPI_CMD_ONESHOT_EN
    chk("oneshot_zero_err", 16'(o_err), 16'h0000);
`else
    chk("oneshot_zero_err", 16'(o_err), 16'h0001);
`endif

    // undefined opcode, then lock leaves the PWM running
    send_word(16'h7123, 3, 3);
    wait_cycles(2);
    chk("undef_err", 16'(o_err), 16'h0001);
    chk("undef_gpo", 16'(o_gpo), 16'h0055);
    send_word(16'h1003, 3, 3);
    send_word(16'h2009, 3, 3);
    send_word(16'h3001, 3, 3);
    send_word(16'hF000, 3, 3);
    wait_cycles(3);
    chk("lock_unl", 16'(o_unlocked), 16'h0000);
    wait_cycles(12);
    count_pwm(30, hi_cnt);
    chk("lock_pwm_runs", 16'(hi_cnt), 16'd9);

    // asynchronous reset in the middle of a long one-shot
    send_word(16'hCAFE, 3, 3);
    send_word(16'h5100, 3, 3);
    wait_cycles(10);
`ifdef SPI_CMD_ONESHOT_EN
    chk("long_busy", 16'(o_busy), 16'h0001);
`else
    chk("long_busy", 16'(o_busy), 16'h0000);
`endif
    @(negedge i_clk);
    #3 i_resetn = 1'b0;
    #1;
    chk("arst_pulse", 16'(o_pulse),    16'h0000);
    chk("arst_busy",  16'(o_busy),     16'h0000);
    chk("arst_pwm",   16'(o_pwm),      16'h0000);
    chk("arst_gpo",   16'(o_gpo),      16'h0000);
    chk("arst_unl",   16'(o_unlocked), 16'h0000);
    chk("arst_err",   16'(o_err),      16'h0000);
    wait_cycles(2);
    i_resetn = 1'b1;
    wait_cycles(2);

    // randomized word stream against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 12) begin
        w = 16'hCAFE;
      end else begin
        op = 4'($urandom_range(0, 15));
        case (op)
          4'h1: arg = 12'($urandom_range(0, 20));
          4'h2: arg = 12'($urandom_range(0, 15));
          4'h3: arg = 12'($urandom_range(0, 1));
          4'h5: arg = 12'($urandom_range(0, 12));
          4'hF: begin
            arg = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) op = 4'h4;
          end
          default: arg = 12'($urandom_range(0, 4095));
        endcase
        w = {op, arg};
      end
      send_word(w, $urandom_range(1, 4), $urandom_range(3, 6));
    end
    wait_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
